// File: rtl/fft_reorder_8point.sv
// Ping-pong reorder buffer: takes 8-sample FFT frames in bit-reversed order and
// replays each one in natural order (X0..X7) over a ready/valid interface.
module fft_reorder_8point #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    input  logic         in_sync,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [2:0]   out_index,
    output logic         out_last,
    output logic         frame_err
);

    logic [1:0][7:0][n-1:0] mem_q, mem_d;
    logic [1:0]             full_q, full_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [2:0]             wr_cnt_q, wr_cnt_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [2:0]             rd_cnt_q, rd_cnt_d;
    logic                   frame_err_q, frame_err_d;

    logic                   wr_acc;
    logic                   rd_acc;
    logic [2:0]             wr_addr;

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem_q[rd_bank_q][rd_cnt_q];
    assign out_index = rd_cnt_q;
    assign out_last  = out_valid & (rd_cnt_q == 3'd7);
    assign frame_err = frame_err_q;

    assign wr_acc  = in_valid & in_ready;
    assign rd_acc  = out_valid & out_ready;
    assign wr_addr = {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]};

    always_comb begin
        mem_d       = mem_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        frame_err_d = 1'b0;

        // A mid-frame sync restarts the frame in place: the sync sample becomes sample 0.
        if (wr_acc) begin
            if (in_sync && (wr_cnt_q != 3'd0)) begin
                mem_d[wr_bank_q][3'd0] = in_data;
                wr_cnt_d               = 3'd1;
                frame_err_d            = 1'b1;
            end else begin
                mem_d[wr_bank_q][wr_addr] = in_data;
                wr_cnt_d                  = wr_cnt_q + 3'd1;
                if (wr_cnt_q == 3'd7) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
        end

        // Write and read never touch the same full flag in one cycle: a bank is
        // written only while empty and read only while full.
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
            if (rd_cnt_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            mem_q       <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= 3'd0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= 3'd0;
            frame_err_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
